// File: rtl/accumulator_scheduler_pkg.sv
// Shared types and helpers for the round-robin accumulator scheduler:
// FSM states, index-width function and the saturating-add result.
package accumulator_scheduler_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RESPOND = 1'b1
  } sched_state_t;

  // Arithmetic runs at this fixed width; WORD_WIDTH must stay below it so
  // the sign-extended sum of two words can never wrap.
  localparam int SAT_WIDTH = 64;

  typedef struct packed {
    logic signed [SAT_WIDTH-1:0] value;
    logic                        saturated;
  } sat_result_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic sat_result_t sat_add(
    input logic signed [SAT_WIDTH-1:0] acc,
    input logic signed [SAT_WIDTH-1:0] inc,
    input logic signed [SAT_WIDTH-1:0] max_lim,
    input logic signed [SAT_WIDTH-1:0] min_lim
  );
    sat_result_t                 r;
    logic signed [SAT_WIDTH-1:0] sum;
    sum         = acc + inc;
    r.value     = sum;
    r.saturated = 1'b0;
    if (sum > max_lim) begin
      r.value     = max_lim;
      r.saturated = 1'b1;
    end else if (sum < min_lim) begin
      r.value     = min_lim;
      r.saturated = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arbiter_round_robin.sv
// Combinational round-robin arbiter: the first request found searching
// cyclically from pointer+1 wins a one-hot grant.
module arbiter_round_robin #(
  parameter int REQUESTER_COUNT = 4,
  parameter int IDX_WIDTH       = 2
) (
  input  logic [REQUESTER_COUNT-1:0] requests,
  input  logic [IDX_WIDTH-1:0]       pointer,
  input  logic                       enable,
  output logic [REQUESTER_COUNT-1:0] grant,
  output logic [IDX_WIDTH-1:0]       index
);

  logic [IDX_WIDTH-1:0]       cand [REQUESTER_COUNT];
  logic [REQUESTER_COUNT-1:0] cand_hit;
  logic                       found;

  // cand[gi] is the requester examined at search position gi.
  for (genvar gi = 0; gi < REQUESTER_COUNT; gi++) begin : g_cand
    logic [IDX_WIDTH:0] raw;
    assign raw = {1'b0, pointer} + (IDX_WIDTH+1)'(gi + 1);
    assign cand[gi] = (raw >= (IDX_WIDTH+1)'(REQUESTER_COUNT))
                      ? IDX_WIDTH'(raw - (IDX_WIDTH+1)'(REQUESTER_COUNT))
                      : IDX_WIDTH'(raw);
    assign cand_hit[gi] = requests[cand[gi]];
  end

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int k = 0; k < REQUESTER_COUNT; k++) begin
      if (enable && !found && cand_hit[k]) begin
        found          = 1'b1;
        grant[cand[k]] = 1'b1;
        index          = cand[k];
      end
    end
  end

endmodule

// File: rtl/accumulator_round_robin_scheduler.sv
// One signed saturating accumulator shared by several requesters through a
// round-robin grant, with a privileged load port and a tagged response.
module accumulator_round_robin_scheduler
  import accumulator_scheduler_pkg::*;
#(
  parameter int WORD_WIDTH      = 16,
  parameter int REQUESTER_COUNT = 4,
  parameter int INITIAL_VALUE   = 0,
  localparam int IDX_WIDTH      = clog2(REQUESTER_COUNT)
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  clear,
  input  logic signed [WORD_WIDTH-1:0]          max_limit,
  input  logic signed [WORD_WIDTH-1:0]          min_limit,
  input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] request_increment,
  input  logic [REQUESTER_COUNT-1:0]            request_valid,
  output logic [REQUESTER_COUNT-1:0]            request_ready,
  input  logic signed [WORD_WIDTH-1:0]          load_value,
  input  logic                                  load_valid,
  output logic                                  load_ready,
  output logic                                  response_valid,
  input  logic                                  response_ready,
  output logic signed [WORD_WIDTH-1:0]          response_value,
  output logic [IDX_WIDTH-1:0]                  response_requester,
  output logic                                  response_overflow,
  output logic signed [WORD_WIDTH-1:0]          accumulated_value
);

  localparam logic signed [WORD_WIDTH-1:0] INIT_WORD  = WORD_WIDTH'(INITIAL_VALUE);
  localparam logic [IDX_WIDTH-1:0]         LAST_INDEX = IDX_WIDTH'(REQUESTER_COUNT - 1);

  sched_state_t                 state_reg, state_next;
  logic signed [WORD_WIDTH-1:0] acc_reg, acc_next;
  logic [IDX_WIDTH-1:0]         ptr_reg, ptr_next;
  logic [IDX_WIDTH-1:0]         rsp_req_reg, rsp_req_next;
  logic                         ovf_reg, ovf_next;

  logic                         can_issue;
  logic                         arb_enable;
  logic                         inc_fire;
  logic [REQUESTER_COUNT-1:0]   grant;
  logic [IDX_WIDTH-1:0]         grant_index;
  logic signed [WORD_WIDTH-1:0] inc_array [REQUESTER_COUNT];
  logic signed [WORD_WIDTH-1:0] inc_sel;
  sat_result_t                  sat_result;

  for (genvar gi = 0; gi < REQUESTER_COUNT; gi++) begin : g_unpack
    assign inc_array[gi] = request_increment[gi*WORD_WIDTH +: WORD_WIDTH];
  end

  // The slot is free when idle or when the pending response drains this edge;
  // readies stay low while reset_n is held so nothing is offered in reset.
  assign can_issue  = reset_n && !clear && ((state_reg == IDLE) || response_ready);
  assign load_ready = can_issue && load_valid;
  assign arb_enable = can_issue && !load_valid;

  arbiter_round_robin #(
    .REQUESTER_COUNT(REQUESTER_COUNT),
    .IDX_WIDTH      (IDX_WIDTH)
  ) u_arbiter (
    .requests(request_valid),
    .pointer (ptr_reg),
    .enable  (arb_enable),
    .grant   (grant),
    .index   (grant_index)
  );

  assign request_ready = grant;
  assign inc_fire      = |grant;
  assign inc_sel       = inc_array[grant_index];
  assign sat_result    = sat_add(SAT_WIDTH'(acc_reg), SAT_WIDTH'(inc_sel),
                                 SAT_WIDTH'(max_limit), SAT_WIDTH'(min_limit));

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    ptr_next     = ptr_reg;
    rsp_req_next = rsp_req_reg;
    ovf_next     = ovf_reg;
    if (clear) begin
      state_next = IDLE;
      acc_next   = INIT_WORD;
      ovf_next   = 1'b0;
    end else if (load_ready) begin
      state_next = IDLE;
      acc_next   = load_value;
      ovf_next   = 1'b0;
    end else if (inc_fire) begin
      state_next   = RESPOND;
      acc_next     = WORD_WIDTH'(sat_result.value);
      ovf_next     = sat_result.saturated;
      rsp_req_next = grant_index;
      ptr_next     = grant_index;
    end else if ((state_reg == RESPOND) && response_ready) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      acc_reg     <= INIT_WORD;
      ptr_reg     <= LAST_INDEX;
      rsp_req_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      ptr_reg     <= ptr_next;
      rsp_req_reg <= rsp_req_next;
      ovf_reg     <= ovf_next;
    end
  end

  // The accumulator only moves on an issue, so it doubles as the response.
  assign response_valid     = (state_reg == RESPOND);
  assign response_value     = acc_reg;
  assign accumulated_value  = acc_reg;
  assign response_requester = rsp_req_reg;
  assign response_overflow  = ovf_reg;

endmodule

// File: tb/tb_accumulator_round_robin_scheduler.sv
// Scenario bench for accumulator_round_robin_scheduler with a transaction-level
// reference model; prints one line per accepted operation.
module tb_accumulator_round_robin_scheduler;

  localparam int WW   = 8;
  localparam int RC   = 4;
  localparam int INIT = 5;
  localparam int IW   = 2;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b1;
  logic                 clear = 1'b0;
  logic signed [WW-1:0] max_limit = 8'sd127;
  logic signed [WW-1:0] min_limit = -8'sd128;
  logic [RC*WW-1:0]     request_increment = '0;
  logic [RC-1:0]        request_valid = '0;
  logic [RC-1:0]        request_ready;
  logic signed [WW-1:0] load_value = '0;
  logic                 load_valid = 1'b0;
  logic                 load_ready;
  logic                 response_valid;
  logic                 response_ready = 1'b1;
  logic signed [WW-1:0] response_value;
  logic [IW-1:0]        response_requester;
  logic                 response_overflow;
  logic signed [WW-1:0] accumulated_value;

  int checks   = 0;
  int failures = 0;

  // Reference model state: running sum, last granted index, pending response.
  int m_acc, m_ptr, m_req;
  bit m_valid, m_ovf;

  accumulator_round_robin_scheduler #(
    .WORD_WIDTH     (WW),
    .REQUESTER_COUNT(RC),
    .INITIAL_VALUE  (INIT)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .clear             (clear),
    .max_limit         (max_limit),
    .min_limit         (min_limit),
    .request_increment (request_increment),
    .request_valid     (request_valid),
    .request_ready     (request_ready),
    .load_value        (load_value),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .response_valid    (response_valid),
    .response_ready    (response_ready),
    .response_value    (response_value),
    .response_requester(response_requester),
    .response_overflow (response_overflow),
    .accumulated_value (accumulated_value)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int inc_of(input int i);
    logic signed [WW-1:0] v;
    v = request_increment[i*WW +: WW];
    return int'(v);
  endfunction

  function automatic int pick();
    for (int k = 1; k <= RC; k++) begin
      int c = (m_ptr + k) % RC;
      if (request_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit model_can();
    return reset_n && !clear && (!m_valid || response_ready);
  endfunction

  function automatic logic [RC-1:0] exp_req_ready();
    logic [RC-1:0] r;
    int g;
    r = '0;
    g = pick();
    if (model_can() && !load_valid && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_acc = INIT; m_ptr = RC - 1; m_req = 0; m_ovf = 0; m_valid = 0;
  endtask

  task automatic set_inc(input int i, input int v);
    request_increment[i*WW +: WW] = WW'(v);
  endtask

  // One clock edge: the model consumes the inputs seen at that edge.
  task automatic advance();
    int g, sum;
    bit can;
    g   = pick();
    can = model_can();
    @(posedge clock);
    if (!reset_n) begin
      model_reset();
    end else if (clear) begin
      m_acc = INIT; m_valid = 0; m_ovf = 0;
      $display("t=%0t clear -> acc=%0d", $time, m_acc);
    end else if (can && load_valid) begin
      m_acc = int'(load_value); m_ovf = 0; m_valid = 0;
      $display("t=%0t load %0d", $time, m_acc);
    end else if (can && g >= 0) begin
      sum = m_acc + inc_of(g);
      if (sum > int'(max_limit)) begin m_acc = int'(max_limit); m_ovf = 1; end
      else if (sum < int'(min_limit)) begin m_acc = int'(min_limit); m_ovf = 1; end
      else begin m_acc = sum; m_ovf = 0; end
      m_req = g; m_ptr = g; m_valid = 1;
      $display("t=%0t grant req=%0d inc=%0d -> value=%0d ovf=%0d", $time, g, inc_of(g), m_acc, m_ovf);
    end else if (m_valid && response_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    request_valid = '1; load_valid = 1'b1; response_ready = 1'b1;
    for (int i = 0; i < RC; i++) set_inc(i, 1);
    #1 reset_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (request_ready !== '0 || load_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: req=%b load=%b required 0", request_ready, load_ready);
    end
    checks++;
    if (response_valid !== 1'b0 || accumulated_value !== WW'(INIT) || response_requester !== '0 || response_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b acc=%0d req=%0d ovf=%b required 0/%0d/0/0",
               response_valid, accumulated_value, response_requester, response_overflow, INIT);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1; request_valid = '0; load_valid = 1'b0;
    #1;
    checks++;
    if (request_ready !== '0 || load_ready !== 1'b0 || accumulated_value !== WW'(INIT)) begin
      failures++;
      $display("FAIL after_release: req=%b load=%b acc=%0d required 0/0/%0d", request_ready, load_ready, accumulated_value, INIT);
    end
    advance();
  endtask

  task automatic test_round_robin();
    int exp_idx [5] = '{0, 1, 2, 3, 0};
    logic [RC-1:0] one_hot;
    load_valid = 1'b1; load_value = '0; response_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (load_ready !== 1'b1) begin failures++; $display("FAIL rr_load_ready: got %b required 1", load_ready); end
    advance();
    load_valid = 1'b0; request_valid = '1;
    for (int i = 0; i < RC; i++) set_inc(i, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      one_hot = '0; one_hot[exp_idx[k]] = 1'b1;
      checks++;
      if (request_ready !== one_hot) begin
        failures++; $display("FAIL rr_grant%0d: got %b required %b", k, request_ready, one_hot);
      end
      advance();
      checks++;
      if (response_valid !== 1'b1 || response_requester !== IW'(exp_idx[k]) || response_value !== WW'(k + 1)) begin
        failures++;
        $display("FAIL rr_response%0d: valid=%b idx=%0d value=%0d required 1/%0d/%0d",
                 k, response_valid, response_requester, response_value, exp_idx[k], k + 1);
      end
    end
    request_valid = '0;
    advance();
  endtask

  task automatic test_saturation();
    bit is_load [8] = '{1, 0, 0, 0, 0, 1, 0, 0};
    int val     [8] = '{120, 10, -5, -128, -128, 90, 10, 1};
    int mx      [8] = '{127, 127, 127, 127, 100, 100, 100, 100};
    int mn      [8] = '{-128, -128, -128, -128, -50, -50, -50, -50};
    int ev      [8] = '{120, 127, 122, -6, -50, 90, 100, 100};
    bit eo      [8] = '{0, 1, 0, 0, 1, 0, 0, 1};
    response_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      max_limit = WW'(mx[k]); min_limit = WW'(mn[k]);
      if (is_load[k]) begin
        load_valid = 1'b1; load_value = WW'(val[k]); request_valid = '0;
      end else begin
        load_valid = 1'b0; request_valid = 4'b0100; set_inc(2, val[k]);
      end
      advance();
      checks++;
      if (accumulated_value !== WW'(ev[k]) || response_overflow !== eo[k] || response_valid !== !is_load[k]) begin
        failures++;
        $display("FAIL sat_step%0d: acc=%0d ovf=%b valid=%b required %0d/%b/%b",
                 k, accumulated_value, response_overflow, response_valid, ev[k], eo[k], !is_load[k]);
      end
    end
    load_valid = 1'b0; request_valid = '0;
    max_limit = 8'sd127; min_limit = -8'sd128;
    advance();
  endtask

  task automatic test_backpressure();
    response_ready = 1'b0; request_valid = 4'b0010; set_inc(1, 3);
    advance();
    checks++;
    if (response_valid !== 1'b1 || response_value !== 8'sd103 || response_requester !== 2'd1) begin
      failures++;
      $display("FAIL bp_accept: valid=%b value=%0d idx=%0d required 1/103/1", response_valid, response_value, response_requester);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (request_ready !== '0 || load_ready !== 1'b0) begin
        failures++; $display("FAIL bp_ready%0d: req=%b load=%b required 0", k, request_ready, load_ready);
      end
      advance();
      checks++;
      if (response_valid !== 1'b1 || response_value !== 8'sd103 || accumulated_value !== 8'sd103 || response_requester !== 2'd1) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b value=%0d idx=%0d required 1/103/1", k, response_valid, response_value, response_requester);
      end
    end
    response_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (request_ready !== 4'b0010) begin
      failures++; $display("FAIL bp_release_grant: got %b required 0010", request_ready);
    end
    advance();
    checks++;
    if (response_valid !== 1'b1 || response_value !== 8'sd106) begin
      failures++; $display("FAIL bp_release_value: valid=%b value=%0d required 1/106", response_valid, response_value);
    end
    request_valid = '0;
    advance();
  endtask

  task automatic test_load_priority();
    load_valid = 1'b1; load_value = -8'sd20; request_valid = 4'b0010; set_inc(1, 7);
    @(negedge clock);
    checks++;
    if (load_ready !== 1'b1 || request_ready !== '0) begin
      failures++; $display("FAIL lp_priority: load=%b req=%b required 1/0000", load_ready, request_ready);
    end
    advance();
    checks++;
    if (accumulated_value !== -8'sd20 || response_valid !== 1'b0) begin
      failures++; $display("FAIL lp_loaded: acc=%0d valid=%b required -20/0", accumulated_value, response_valid);
    end
    load_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (request_ready !== 4'b0010) begin
      failures++; $display("FAIL lp_next_grant: got %b required 0010", request_ready);
    end
    advance();
    checks++;
    if (response_value !== -8'sd13 || response_requester !== 2'd1 || response_valid !== 1'b1) begin
      failures++;
      $display("FAIL lp_result: value=%0d idx=%0d valid=%b required -13/1/1", response_value, response_requester, response_valid);
    end
    request_valid = '0;
    advance();
  endtask

  task automatic test_clear();
    response_ready = 1'b0; request_valid = 4'b0001; set_inc(0, 4);
    advance();
    checks++;
    if (response_valid !== 1'b1 || response_value !== -8'sd9) begin
      failures++; $display("FAIL clr_setup: valid=%b value=%0d required 1/-9", response_valid, response_value);
    end
    clear = 1'b1; response_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (request_ready !== '0) begin
      failures++; $display("FAIL clr_no_grant: got %b required 0000", request_ready);
    end
    advance();
    checks++;
    if (response_valid !== 1'b0 || accumulated_value !== WW'(INIT) || response_overflow !== 1'b0) begin
      failures++;
      $display("FAIL clr_result: valid=%b acc=%0d ovf=%b required 0/%0d/0", response_valid, accumulated_value, response_overflow, INIT);
    end
    clear = 1'b0; request_valid = '0;
    advance();
  endtask

  task automatic test_async_reset();
    response_ready = 1'b1; request_valid = '1; max_limit = 8'sd6;
    for (int i = 0; i < RC; i++) set_inc(i, 2);
    advance();
    advance();
    checks++;
    if (response_valid !== 1'b1 || response_value !== 8'sd6 || response_overflow !== 1'b1 || response_requester !== IW'(m_req)) begin
      failures++;
      $display("FAIL ar_setup: valid=%b value=%0d ovf=%b idx=%0d required 1/6/1/%0d",
               response_valid, response_value, response_overflow, response_requester, m_req);
    end
    load_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (response_valid !== 1'b0 || accumulated_value !== WW'(INIT) || response_requester !== '0 ||
        response_overflow !== 1'b0 || request_ready !== '0 || load_ready !== 1'b0) begin
      failures++;
      $display("FAIL ar_immediate: valid=%b acc=%0d idx=%0d ovf=%b req=%b load=%b required 0/%0d/0/0/0/0",
               response_valid, accumulated_value, response_requester, response_overflow, request_ready, load_ready, INIT);
    end
    @(negedge clock);
    reset_n = 1'b1; load_valid = 1'b0; max_limit = 8'sd127;
    #1;
    checks++;
    if (request_ready !== 4'b0001) begin
      failures++; $display("FAIL ar_first_priority: got %b required 0001", request_ready);
    end
    advance();
    request_valid = '0;
    advance();
  endtask

  task automatic test_random();
    int a, b;
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) begin
        a = $urandom_range(255) - 128;
        b = $urandom_range(255) - 128;
        max_limit = WW'((a > b) ? a : b);
        min_limit = WW'((a > b) ? b : a);
      end
      request_valid  = RC'($urandom);
      for (int i = 0; i < RC; i++) set_inc(i, $urandom_range(255) - 128);
      load_valid     = ($urandom_range(7) == 0);
      load_value     = WW'($urandom);
      clear          = ($urandom_range(31) == 0);
      response_ready = ($urandom_range(3) != 0);
      @(negedge clock);
      checks++;
      if (request_ready !== exp_req_ready() || load_ready !== (model_can() && load_valid)) begin
        failures++;
        $display("FAIL rnd_ready%0d: req=%b load=%b required %b/%b", n, request_ready, load_ready, exp_req_ready(), model_can() && load_valid);
      end
      advance();
      checks++;
      if (response_valid !== m_valid || accumulated_value !== WW'(m_acc) || response_value !== WW'(m_acc) ||
          response_requester !== IW'(m_req) || response_overflow !== m_ovf) begin
        failures++;
        $display("FAIL rnd_out%0d: valid=%b acc=%0d idx=%0d ovf=%b required %b/%0d/%0d/%b",
                 n, response_valid, accumulated_value, response_requester, response_overflow, m_valid, m_acc, m_req, m_ovf);
      end
    end
    clear = 1'b0; load_valid = 1'b0; request_valid = '0; response_ready = 1'b1;
    advance();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_saturation();
    test_backpressure();
    test_load_priority();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
